// File: rtl/mix_bus_sequencer_if.sv
// Sample-bus bundle between the oscillator side and the mixer side of mix_bus_sequencer.
// i_trigger exists only when MIX_EXT_TRIGGER_EN is defined.
interface mix_bus_sequencer_if;
    logic       i_enable;
    logic [7:0] i_osc1_sample;
    logic [7:0] i_osc2_sample;
    logic [2:0] i_level_1;
    logic [2:0] i_level_2;
`ifdef MIX_EXT_TRIGGER_EN
    logic       i_trigger;
`endif
    logic [7:0] o_sample;
    logic       o_sample_1_load;
    logic       o_sample_2_load;
    logic       o_execute;
    logic [2:0] o_sample_1_level;
    logic [2:0] o_sample_2_level;
    logic       o_busy;
    logic       o_overrun;

    modport master (
`ifdef MIX_EXT_TRIGGER_EN
        input  i_trigger,
`endif
        input  i_enable, i_osc1_sample, i_osc2_sample, i_level_1, i_level_2,
        output o_sample, o_sample_1_load, o_sample_2_load, o_execute,
        output o_sample_1_level, o_sample_2_level, o_busy, o_overrun
    );

    modport slave (
`ifdef MIX_EXT_TRIGGER_EN
        output i_trigger,
`endif
        output i_enable, i_osc1_sample, i_osc2_sample, i_level_1, i_level_2,
        input  o_sample, o_sample_1_load, o_sample_2_load, o_execute,
        input  o_sample_1_level, o_sample_2_level, o_busy, o_overrun
    );
endinterface

// File: rtl/mix_bus_sequencer.sv
// Multiplexes two oscillator samples onto one bus as a LOAD1/LOAD2/EXEC frame per sample period.
// Define MIX_EXT_TRIGGER_EN to request frames from i_trigger rising edges instead of the internal divider.
module mix_bus_sequencer #(
    parameter int CLK_DIV = 256,
    parameter int DIV_W   = 16
) (
    input  logic               i_clock,
    input  logic               i_reset,
    mix_bus_sequencer_if.master bus
);

    typedef enum logic [1:0] {IDLE, LOAD1, LOAD2, EXEC} state_t;

    state_t     state_q;
    logic [7:0] sample_q;
    logic [7:0] snap2_q;
    logic [2:0] level1_q;
    logic [2:0] level2_q;
    logic       load1_q;
    logic       load2_q;
    logic       exec_q;
    logic       busy_q;
    logic       overrun_q;
    logic       req;

    function automatic logic [2:0] clamp_level(input logic [2:0] code);
        return (code > 3'd5) ? 3'd5 : code;
    endfunction

`ifdef MIX_EXT_TRIGGER_EN
    // Two sync flops, then a registered edge detect: LOAD1 lands 4 cycles after the rise.
    logic sync1_q, sync2_q, prev_q, edge_q;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= bus.i_trigger;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            edge_q  <= sync2_q & ~prev_q;
        end
    end

    assign req = edge_q & bus.i_enable;
`else
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;

    always_comb begin
        div_d = '0;
        if (bus.i_enable && (div_q != DIV_LAST))
            div_d = div_q + 1'b1;
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset)
            div_q <= '0;
        else
            div_q <= div_d;
    end

    assign req = bus.i_enable && (div_q == DIV_LAST);
`endif

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= IDLE;
            sample_q  <= '0;
            snap2_q   <= '0;
            level1_q  <= '0;
            level2_q  <= '0;
            load1_q   <= 1'b0;
            load2_q   <= 1'b0;
            exec_q    <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            load1_q <= 1'b0;
            load2_q <= 1'b0;
            exec_q  <= 1'b0;
            if (req && (state_q != IDLE))
                overrun_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    // The bus register doubles as the source-1 snapshot.
                    if (req) begin
                        state_q  <= LOAD1;
                        sample_q <= bus.i_osc1_sample;
                        snap2_q  <= bus.i_osc2_sample;
                        level1_q <= clamp_level(bus.i_level_1);
                        level2_q <= clamp_level(bus.i_level_2);
                        load1_q  <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                LOAD1: begin
                    state_q  <= LOAD2;
                    sample_q <= snap2_q;
                    load2_q  <= 1'b1;
                end
                LOAD2: begin
                    state_q <= EXEC;
                    exec_q  <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_sample         = sample_q;
    assign bus.o_sample_1_load  = load1_q;
    assign bus.o_sample_2_load  = load2_q;
    assign bus.o_execute        = exec_q;
    assign bus.o_sample_1_level = level1_q;
    assign bus.o_sample_2_level = level2_q;
    assign bus.o_busy           = busy_q;
    assign bus.o_overrun        = overrun_q;

endmodule
